// File: rtl/check_ram_multilane.sv
// -----------------------------------------------------------------------------
// check_ram_multilane
//
// Multi-lane check RAM for the L2 TLB. Entries are stored in NUM_LANES/2
// replicated dual-port banks (bank k serves lanes 2k and 2k+1), so NUM_LANES
// entries are compared against in_addr every cycle. The first matching lane
// (lowest index) is captured into a held result until the consumer
// acknowledges it with output_sent. Matches on more than one lane flag
// multi_hit.
//
// Entry layout: [RAM_DATA_WIDTH-1:4] VPN tag, [3] master, [2] write enable,
//               [1] read enable, [0] valid.
//
// Optional feature macro: FULL_MULTI_HIT_DETECT_EN
//   defined   : matches seen while a result is held also set multi_hit
//               (sticky until output_sent); the held result is unchanged.
//   undefined : multi_hit reflects only the cycle that captured the result.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   in_addr         virtual address under translation
//   rw_type         1 = write access, 0 = read access
//   ram_we          write ram_wdata at lane 0 address into every bank
//   lane_addr       per-lane read address, lane i at [i*RAM_AW +: RAM_AW]
//   ram_wdata       entry to write
//   output_valid    RAM data for last cycle's addresses is meaningful
//   output_sent     consumer has taken the held result
//   offset_addr_d   offset belonging to the addresses being compared
//   hit_addr        {set part of winning lane address, offset_addr_d}
//   hit_lane        index of the winning lane
//   master          master bit of the winning entry
//   hit             held result valid
//   multi_hit       more than one matching entry detected
//   prot            winning entry lacks permission for rw_type
// -----------------------------------------------------------------------------
module check_ram_multilane #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int PAGE_SIZE      = 4096,
    parameter int SET_WIDTH      = 5,
    parameter int OFFSET_WIDTH   = 4,
    parameter int NUM_LANES      = 4
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic [ADDR_WIDTH-1:0]                              in_addr,
    input  logic                                               rw_type,
    input  logic                                               ram_we,
    input  logic [NUM_LANES*(SET_WIDTH+OFFSET_WIDTH+1)-1:0]    lane_addr,
    input  logic [RAM_DATA_WIDTH-1:0]                          ram_wdata,
    input  logic                                               output_valid,
    input  logic                                               output_sent,
    input  logic [OFFSET_WIDTH-1:0]                            offset_addr_d,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]                    hit_addr,
    output logic [$clog2(NUM_LANES)-1:0]                       hit_lane,
    output logic                                               master,
    output logic                                               hit,
    output logic                                               multi_hit,
    output logic                                               prot
);

    localparam int RAM_AW      = SET_WIDTH + OFFSET_WIDTH + 1;
    localparam int RAM_DEPTH   = 1 << RAM_AW;
    localparam int LANE_W      = $clog2(NUM_LANES);
    localparam int NUM_BANKS   = NUM_LANES / 2;
    localparam int IGNORE_LSB  = $clog2(PAGE_SIZE);
    localparam int TAG_W       = ADDR_WIDTH - IGNORE_LSB;
    localparam int ENTRY_TAG_W = RAM_DATA_WIDTH - 4;
    localparam int SET_HI_W    = RAM_AW - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b01,
        ST_HIT    = 2'b10
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [RAM_DATA_WIDTH-1:0]   w_lane_data [NUM_LANES];
    logic [SET_HI_W-1:0]         r_lane_hi_q [NUM_LANES];
    logic                        r_we_q;
    logic [RAM_AW-1:0]           w_wr_addr;

    logic [TAG_W-1:0]            w_tag;
    logic                        w_unused_lsb;
    logic [NUM_LANES-1:0]        w_match;
    logic                        w_any;
    logic                        w_multi;
    logic [LANE_W-1:0]           w_win;
    logic [3:1]                  w_win_flags;
    logic                        w_win_prot;
    logic [RAM_AW-1:0]           w_win_addr;

    logic                        w_capture;
    logic                        w_release;
    logic                        w_set_multi;

    logic                        r_hit;
    logic                        r_multi_hit;
    logic                        r_prot;
    logic                        r_master;
    logic [RAM_AW-1:0]           r_hit_addr;
    logic [LANE_W-1:0]           r_hit_lane;

    assign w_wr_addr = lane_addr[RAM_AW-1:0];

    // ---- Stage 0 -> 1: replicated RAM banks, lane address / write capture ----
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [RAM_DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
        logic [RAM_DATA_WIDTH-1:0] r_rd_a;
        logic [RAM_DATA_WIDTH-1:0] r_rd_b;

        // Port A shares the write address; in no-change mode its output holds
        // during a write (that cycle's data is masked by r_we_q anyway).
        always_ff @(posedge clk_i) begin
            if (ram_we) begin
                r_mem[w_wr_addr] <= ram_wdata;
            end else begin
                r_rd_a <= r_mem[lane_addr[(2*k)*RAM_AW +: RAM_AW]];
            end
        end

        // Port B is read-only and returns the pre-write contents.
        always_ff @(posedge clk_i) begin
            r_rd_b <= r_mem[lane_addr[(2*k+1)*RAM_AW +: RAM_AW]];
        end

        assign w_lane_data[2*k]   = r_rd_a;
        assign w_lane_data[2*k+1] = r_rd_b;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            r_lane_hi_q[i] <= lane_addr[i*RAM_AW + OFFSET_WIDTH +: SET_HI_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we_q <= 1'b0;
        end else begin
            r_we_q <= ram_we;
        end
    end

    // ---- Stage 1: compare, priority select, multi-match ----
    assign w_tag        = in_addr[ADDR_WIDTH-1:IGNORE_LSB];
    assign w_unused_lsb = ^in_addr[IGNORE_LSB-1:0];

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_match[i] = w_lane_data[i][0]
                      && (w_lane_data[i][RAM_DATA_WIDTH-1:4] == ENTRY_TAG_W'(w_tag))
                      && output_valid
                      && !r_we_q;
        end
    end

    always_comb begin
        logic seen;
        w_win   = '0;
        w_multi = 1'b0;
        seen    = 1'b0;
        // Descending scan so the lowest matching index is the last to write.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_win = LANE_W'(i);
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_match[i]) begin
                if (seen) begin
                    w_multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    assign w_any       = |w_match;
    assign w_win_flags = w_lane_data[w_win][3:1];
    assign w_win_prot  = rw_type ? ~w_win_flags[2] : ~w_win_flags[1];
    assign w_win_addr  = {r_lane_hi_q[w_win], offset_addr_d};

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: if (w_any)       w_state_nxt = ST_HIT;
            ST_HIT:    if (output_sent) w_state_nxt = ST_SEARCH;
            default:                    w_state_nxt = ST_SEARCH;
        endcase
    end

    // ---- FSM: output strobes ----
    always_comb begin
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_set_multi = 1'b0;
        case (r_state)
            ST_SEARCH: w_capture = w_any;
            ST_HIT: begin
                // A match in the release cycle is dropped; the controller restarts.
                w_release = output_sent;
`ifdef FULL_MULTI_HIT_DETECT_EN
                w_set_multi = w_any && !output_sent;
`else
                w_set_multi = 1'b0;
`endif
            end
            default: w_release = 1'b1;
        endcase
    end

    // ---- Stage 1 -> 2: held result registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit       <= 1'b0;
            r_multi_hit <= 1'b0;
            r_prot      <= 1'b0;
            r_master    <= 1'b0;
            r_hit_addr  <= '0;
            r_hit_lane  <= '0;
        end else if (w_capture) begin
            r_hit       <= 1'b1;
            r_multi_hit <= w_multi;
            r_prot      <= w_win_prot;
            r_master    <= w_win_flags[3];
            r_hit_addr  <= w_win_addr;
            r_hit_lane  <= w_win;
        end else if (w_release) begin
            r_hit       <= 1'b0;
            r_multi_hit <= 1'b0;
            r_prot      <= 1'b0;
        end else if (w_set_multi) begin
            r_multi_hit <= 1'b1;
        end
    end

    assign hit       = r_hit;
    assign multi_hit = r_multi_hit;
    assign prot      = r_prot;
    assign master    = r_master;
    assign hit_addr  = r_hit_addr;
    assign hit_lane  = r_hit_lane;

endmodule

// File: tb/tb_check_ram_multilane.sv
module tb_check_ram_multilane;

    localparam int NL  = 4;
    localparam int RAW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [31:0]       in_addr;
    logic              rw_type;
    logic              ram_we;
    logic [NL*RAW-1:0] lane_addr;
    logic [31:0]       ram_wdata;
    logic              output_valid;
    logic              output_sent;
    logic [3:0]        offset_addr_d;
    logic [9:0]        hit_addr;
    logic [1:0]        hit_lane;
    logic              master;
    logic              hit;
    logic              multi_hit;
    logic              prot;

    check_ram_multilane dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_addr       (in_addr),
        .rw_type       (rw_type),
        .ram_we        (ram_we),
        .lane_addr     (lane_addr),
        .ram_wdata     (ram_wdata),
        .output_valid  (output_valid),
        .output_sent   (output_sent),
        .offset_addr_d (offset_addr_d),
        .hit_addr      (hit_addr),
        .hit_lane      (hit_lane),
        .master        (master),
        .hit           (hit),
        .multi_hit     (multi_hit),
        .prot          (prot)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: entry table plus the held translation result.
    logic [31:0] mem [1024];
    logic [31:0] p_data [NL];
    logic [9:0]  p_addr [NL];
    logic        p_we;
    logic        m_hit, m_multi, m_prot, m_master;
    logic [9:0]  m_addr;
    logic [1:0]  m_lane;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hit = 0; m_multi = 0; m_prot = 0; m_master = 0; m_addr = '0; m_lane = '0;
        p_we = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int cnt;
        int first;
        logic [9:0] la;
        cnt = 0;
        first = -1;
        if (rst_n) begin
            for (int i = 0; i < NL; i++) begin
                if (p_data[i][0] && p_data[i][31:4] == {8'h00, in_addr[31:12]}
                    && output_valid && !p_we) begin
                    cnt++;
                    if (first < 0) first = i;
                end
            end
            if (!m_hit) begin
                if (cnt > 0) begin
                    m_hit    = 1;
                    m_lane   = 2'(first);
                    m_addr   = {p_addr[first][9:4], offset_addr_d};
                    m_master = p_data[first][3];
                    m_prot   = rw_type ? !p_data[first][2] : !p_data[first][1];
                    m_multi  = (cnt >= 2);
                end
            end else if (output_sent) begin
                m_hit = 0; m_prot = 0; m_multi = 0;
            end
`ifdef FULL_MULTI_HIT_DETECT_EN
            else if (cnt > 0) begin
                m_multi = 1;
            end
`endif
        end
        for (int i = 0; i < NL; i++) begin
            la = lane_addr[i*RAW +: RAW];
            p_data[i] = mem[la];
            p_addr[i] = la;
        end
        p_we = rst_n ? ram_we : 1'b0;
        if (ram_we) mem[lane_addr[RAW-1:0]] = ram_wdata;
    endtask

    task automatic check_all();
        chk("hit",       32'(hit),       32'(m_hit));
        chk("multi_hit", 32'(multi_hit), 32'(m_multi));
        chk("prot",      32'(prot),      32'(m_prot));
        chk("master",    32'(master),    32'(m_master));
        chk("hit_addr",  32'(hit_addr),  32'(m_addr));
        chk("hit_lane",  32'(hit_lane),  32'(m_lane));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_lanes(input logic [9:0] a0, input logic [9:0] a1,
                             input logic [9:0] a2, input logic [9:0] a3);
        lane_addr = {a3, a2, a1, a0};
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        ram_we = 1; ram_wdata = d; output_valid = 0;
        set_lanes(a, 10'h0, 10'h0, 10'h0);
        tick();
        ram_we = 0;
    endtask

    // Present addresses, then compare them one cycle later; result is visible after.
    task automatic probe(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                         input logic [9:0] a3, input logic rw, input logic [3:0] off);
        output_valid = 0;
        set_lanes(a0, a1, a2, a3);
        tick();
        output_valid = 1; in_addr = 32'h12345abc; rw_type = rw; offset_addr_d = off;
        set_lanes(10'h0, 10'h0, 10'h0, 10'h0);
        tick();
        output_valid = 0;
    endtask

    task automatic send();
        output_sent = 1;
        tick();
        output_sent = 0;
    endtask

    initial begin
        in_addr = '0; rw_type = 0; ram_we = 0; lane_addr = '0; ram_wdata = '0;
        output_valid = 0; output_sent = 0; offset_addr_d = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < NL; i++) begin p_data[i] = '0; p_addr[i] = '0; end
        model_clear();

        // Reset state
        #1 rst_n = 0;
        #2;
        check_all();
        tick();
        tick();
        #2 rst_n = 1;
        tick();

        // Fill the address range used below with entries whose tags never equal 0x12345
        for (int a = 0; a < 32; a++) begin
            wr(10'(a), {8'h00, 20'h00010 + 20'($urandom_range(0, 3)), 4'($urandom)});
        end
        tick();

        // Single hit on lane 2, rw=1, full permissions
        wr(10'h013, 32'h0012_3457);
        probe(10'h000, 10'h000, 10'h013, 10'h000, 1'b1, 4'h5);
        chk("t2_hit",  32'(hit),      32'd1);
        chk("t2_lane", 32'(hit_lane), 32'd2);
        chk("t2_addr", 32'(hit_addr), 32'h015);
        chk("t2_mst",  32'(master),   32'd0);
        chk("t2_prot", 32'(prot),     32'd0);
        tick();
        tick();
        chk("t2_held", 32'(hit), 32'd1);
        send();
        chk("t2_sent", 32'(hit), 32'd0);

        // Missing write permission
        wr(10'h013, 32'h0012_3453);
        probe(10'h000, 10'h000, 10'h013, 10'h000, 1'b1, 4'h2);
        chk("t3_prot_w", 32'(prot), 32'd1);
        send();
        probe(10'h000, 10'h000, 10'h013, 10'h000, 1'b0, 4'h2);
        chk("t3_prot_r", 32'(prot), 32'd0);
        send();

        // Same entry on lanes 1 and 3 in one cycle
        probe(10'h000, 10'h013, 10'h000, 10'h013, 1'b0, 4'h9);
        chk("t4_lane",  32'(hit_lane),  32'd1);
        chk("t4_multi", 32'(multi_hit), 32'd1);
        send();

        // Master bit propagates
        wr(10'h027, 32'h0012_345b);
        probe(10'h000, 10'h000, 10'h000, 10'h027, 1'b0, 4'hc);
        chk("mst_hit",  32'(hit),      32'd1);
        chk("mst_bit",  32'(master),   32'd1);
        chk("mst_addr", 32'(hit_addr), 32'h02c);
        send();

        // Match on lane 2 arriving while lane 0 result is held
        output_valid = 0;
        set_lanes(10'h013, 10'h000, 10'h000, 10'h000);
        tick();
        output_valid = 1; in_addr = 32'h12345abc;
        set_lanes(10'h000, 10'h000, 10'h013, 10'h000);
        tick();
        chk("t5_lane",   32'(hit_lane),  32'd0);
        chk("t5_multi0", 32'(multi_hit), 32'd0);
        set_lanes(10'h000, 10'h000, 10'h000, 10'h000);
        tick();
        output_valid = 0;
`ifdef FULL_MULTI_HIT_DETECT_EN
        chk("t5_multi1", 32'(multi_hit), 32'd1);
`else
        chk("t5_multi1", 32'(multi_hit), 32'd0);
`endif
        chk("t5_held", 32'(hit_lane), 32'd0);
        send();

        // Write cycle masks its read data
        ram_we = 1; ram_wdata = 32'h0012_3457; output_valid = 0;
        set_lanes(10'h013, 10'h013, 10'h013, 10'h013);
        tick();
        ram_we = 0; output_valid = 1; in_addr = 32'h12345abc;
        set_lanes(10'h000, 10'h000, 10'h000, 10'h000);
        tick();
        output_valid = 0;
        tick();
        chk("t6_nohit", 32'(hit), 32'd0);

        // Asynchronous reset while holding a result
        probe(10'h013, 10'h000, 10'h000, 10'h000, 1'b1, 4'h7);
        chk("t1_pre", 32'(hit), 32'd1);
        #2 rst_n = 0;
        #1;
        model_clear();
        chk("t1_hit",  32'(hit),       32'd0);
        chk("t1_addr", 32'(hit_addr),  32'd0);
        chk("t1_lane", 32'(hit_lane),  32'd0);
        check_all();
        tick();
        #2 rst_n = 1;
        tick();
        probe(10'h000, 10'h013, 10'h000, 10'h000, 1'b1, 4'h1);
        chk("t1_again", 32'(hit_lane), 32'd1);
        send();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ram_we        = ($urandom_range(0, 7) == 0);
            ram_wdata     = {8'h00, 20'h00010 + 20'($urandom_range(0, 3)), 4'($urandom)};
            set_lanes(10'($urandom_range(0, 31)), 10'($urandom_range(0, 31)),
                      10'($urandom_range(0, 31)), 10'($urandom_range(0, 31)));
            in_addr       = {20'h00010 + 20'($urandom_range(0, 3)), 12'($urandom)};
            rw_type       = 1'($urandom);
            output_valid  = ($urandom_range(0, 3) != 0);
            output_sent   = ($urandom_range(0, 3) == 0);
            offset_addr_d = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
